// File: rtl/tt_um_mult_if.sv
// Bus bundle for tt_um_mult: run request, activation pairs, config, ternary weights
// and the result stream.
interface tt_um_mult_if #(
  parameter int unsigned MAX_IN_LEN  = 16,
  parameter int unsigned MAX_OUT_LEN = 8
);
  logic                                 ena;
  logic [15:0]                          ui_input;
  logic [6:0]                           ui_param;
  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]  ui_weights;
  logic [15:0]                          uo_output;
  logic                                 uo_valid;
  logic                                 uo_done;

  modport master (
    output ena, ui_input, ui_param, ui_weights,
    input  uo_output, uo_valid, uo_done
  );

  modport slave (
    input  ena, ui_input, ui_param, ui_weights,
    output uo_output, uo_valid, uo_done
  );
endinterface

// File: rtl/tt_um_mult.sv
// Ternary-weight matrix-vector multiplier: consumes two signed activations per cycle,
// accumulates into up to MAX_OUT_LEN sums, then streams the sums out one per cycle.
module tt_um_mult #(
  parameter int unsigned MAX_IN_LEN  = 16,
  parameter int unsigned MAX_OUT_LEN = 8
) (
  input logic         clk,
  input logic         rst,
  tt_um_mult_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMult, StOut, StDone} state_e;

  state_e      state_q, state_d;
  logic        ena_q, ena_d;
  logic [6:0]  param_q, param_d;
  logic [3:0]  pair_q, pair_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] acc_q [MAX_OUT_LEN];
  logic [15:0] acc_d [MAX_OUT_LEN];
  logic [15:0] out_q, out_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  logic [1:0]  w_hi [MAX_OUT_LEN];
  logic [1:0]  w_lo [MAX_OUT_LEN];
  logic        start, last_pair, drop_lo, last_idx;

  function automatic logic [15:0] tern(logic [1:0] w, logic [7:0] x);
    logic [15:0] xs;
    xs = {{8{x[7]}}, x};
    case (w)
      2'b01:   return xs;
      2'b11:   return 16'd0 - xs;
      default: return 16'd0;
    endcase
  endfunction

  assign start     = bus.ena & ~ena_q;
  // Last pair index is (in_len-1)>>1; an odd in_len leaves the final low byte unused.
  assign last_pair = (pair_q == {1'b0, param_q[6:4]});
  assign drop_lo   = last_pair & ~param_q[3];
  assign last_idx  = (idx_q == {1'b0, param_q[2:0]});

  // Weight rows 2k and 2k+1 for the current pair; rows past MAX_IN_LEN read as zero.
  always_comb begin
    for (int j = 0; j < int'(MAX_OUT_LEN); j++) begin
      w_hi[j] = 2'b00;
      w_lo[j] = 2'b00;
      for (int i = 0; i < int'(MAX_IN_LEN); i++) begin
        if (i == 2 * int'(pair_q))     w_hi[j] = bus.ui_weights[2*(i*MAX_OUT_LEN+j) +: 2];
        if (i == 2 * int'(pair_q) + 1) w_lo[j] = bus.ui_weights[2*(i*MAX_OUT_LEN+j) +: 2];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ena_d   = bus.ena;
    param_d = param_q;
    pair_d  = pair_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = valid_q;
    done_d  = done_q;

    case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (start) begin
          param_d = bus.ui_param;
          pair_d  = 4'd0;
          idx_d   = 4'd0;
          for (int j = 0; j < int'(MAX_OUT_LEN); j++) acc_d[j] = 16'd0;
          state_d = StMult;
        end
      end
      StMult: begin
        if (!bus.ena) begin
          state_d = StIdle;
          valid_d = 1'b0;
          out_d   = 16'd0;
        end else begin
          for (int j = 0; j < int'(MAX_OUT_LEN); j++) begin
            if (j <= int'(param_q[2:0])) begin
              acc_d[j] = acc_q[j] + tern(w_hi[j], bus.ui_input[15:8])
                       + (drop_lo ? 16'd0 : tern(w_lo[j], bus.ui_input[7:0]));
            end
          end
          if (last_pair) begin
            idx_d   = 4'd0;
            state_d = StOut;
          end else begin
            pair_d = pair_q + 4'd1;
          end
        end
      end
      StOut: begin
        if (!bus.ena) begin
          state_d = StIdle;
          valid_d = 1'b0;
          out_d   = 16'd0;
        end else begin
          for (int j = 0; j < int'(MAX_OUT_LEN); j++) begin
            if (int'(idx_q) == j) out_d = acc_q[j];
          end
          valid_d = 1'b1;
          if (last_idx) state_d = StDone;
          else          idx_d   = idx_q + 4'd1;
        end
      end
      StDone: begin
        valid_d = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ena_q   <= 1'b0;
      param_q <= 7'h7F;
      pair_q  <= 4'd0;
      idx_q   <= 4'd0;
      for (int j = 0; j < int'(MAX_OUT_LEN); j++) acc_q[j] <= 16'd0;
      out_q   <= 16'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ena_q   <= ena_d;
      param_q <= param_d;
      pair_q  <= pair_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.uo_output = out_q;
  assign bus.uo_valid  = valid_q;
  assign bus.uo_done   = done_q;

endmodule

// File: tb/tb_tt_um_mult.sv
// Directed bench for tt_um_mult: hand-computed result words, latency, pulse width,
// abort, no-restart and asynchronous reset behaviour.
module tb_tt_um_mult;
  localparam int unsigned InLen  = 16;
  localparam int unsigned OutLen = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tt_um_mult_if #(.MAX_IN_LEN(InLen), .MAX_OUT_LEN(OutLen)) bus ();

  tt_um_mult #(.MAX_IN_LEN(InLen), .MAX_OUT_LEN(OutLen)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int                           n_checks = 0;
  int                           n_fail   = 0;
  logic [15:0]                  pairs [8];
  logic [2*InLen*OutLen-1:0]    wts;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete run; every valid word must equal exp_word.
  task automatic run(input string tag, input logic [6:0] prm, input int npairs,
                     input int nout, input logic [15:0] exp_word);
    int first, nvalid, done_cyc, extra;
    first    = -1;
    nvalid   = 0;
    done_cyc = -1;
    bus.ena      = 1'b1;
    bus.ui_param = prm;
    bus.ui_input = pairs[0];
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.ui_param = prm ^ 7'h7F;
      if (cyc - 1 < npairs) bus.ui_input = pairs[cyc-1];
      if (bus.uo_valid) begin
        if (first < 0) first = cyc;
        check({tag, " word"}, 32'(bus.uo_output), 32'(exp_word));
        nvalid++;
      end
      if (bus.uo_done) done_cyc = cyc;
    end
    check({tag, " latency"}, first - 1, npairs + 1);
    check({tag, " valid count"}, nvalid, nout);
    check({tag, " done timing"}, done_cyc, first + nout);
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.uo_valid || bus.uo_done) extra++;
    end
    check({tag, " no restart"}, extra, 0);
    bus.ena = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_basic();
    wts        = '0;
    wts[1:0]   = 2'b01;
    wts[17:16] = 2'b11;
    bus.ui_weights = wts;
    pairs[0] = 16'h0503;
  endtask

  initial begin
    int quiet;
    rst            = 1'b1;
    bus.ena        = 1'b0;
    bus.ui_input   = '0;
    bus.ui_param   = '0;
    bus.ui_weights = '0;
    #12;
    check("reset uo_output", 32'(bus.uo_output), 0);
    check("reset uo_valid", 32'(bus.uo_valid), 0);
    check("reset uo_done", 32'(bus.uo_done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    set_basic();
    run("basic", 7'h08, 1, 1, 16'h0002);

    bus.ui_weights = {128{2'b01}};
    for (int k = 0; k < 8; k++) pairs[k] = 16'h7F7F;
    run("full pos", 7'h7F, 8, 8, 16'h07F0);

    // Mid-MULT reset must clear the held result word immediately.
    bus.ena = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst uo_output", 32'(bus.uo_output), 0);
    check("async rst uo_valid", 32'(bus.uo_valid), 0);
    check("async rst uo_done", 32'(bus.uo_done), 0);
    bus.ena = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    quiet = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.uo_valid || bus.uo_done) quiet++;
    end
    check("idle after rst", quiet, 0);
    set_basic();
    run("fresh after rst", 7'h08, 1, 1, 16'h0002);

    bus.ui_weights = {128{2'b11}};
    for (int k = 0; k < 8; k++) pairs[k] = 16'h8080;
    run("full neg", 7'h7F, 8, 8, 16'h0800);

    bus.ui_weights = {128{2'b10}};
    run("full zero", 7'h7F, 8, 8, 16'h0000);

    bus.ui_weights = {128{2'b01}};
    pairs[0] = 16'h0102;
    pairs[1] = 16'h04FF;
    run("odd len", 7'h11, 2, 2, 16'h0007);

    // Abort: ena low sampled on the third MULT edge.
    for (int k = 0; k < 8; k++) pairs[k] = 16'h7F7F;
    bus.ui_param = 7'h7F;
    bus.ui_input = pairs[0];
    bus.ena      = 1'b1;
    repeat (3) @(negedge clk);
    bus.ena = 1'b0;
    quiet = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.uo_valid || bus.uo_done) quiet++;
    end
    check("abort silent", quiet, 0);
    set_basic();
    run("rerun after abort", 7'h08, 1, 1, 16'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tt_um_mult.md
TT_UM_MULT -- requirements
Module: tt_um_mult

Interface
REQ-001 SHALL have parameter MAX_IN_LEN, default 16, max activation vector length (even).
REQ-002 SHALL have parameter MAX_OUT_LEN, default 8, max output vector length.
REQ-003 SHALL have a single clock and an asynchronous, active-high reset, with ports: clk  input  1  rising-edge clock; rst  input  1  reset.
REQ-004 SHALL have ports: ena  input  1  run request from the top-level controller, level-sensitive, start on its rising edge.
REQ-005 SHALL have ports: ui_input  input  16  activation pair, signed 8b each: [15:8]=x(2k), [7:0]=x(2k+1).
REQ-006 SHALL have ports: ui_param  input  7  config: [6:3]=in_len-1, [2:0]=out_len-1.
REQ-007 SHALL have ports: ui_weights  input  2*MAX_IN_LEN*MAX_OUT_LEN  ternary weights from the load stage; w[i][j] at bits [2*(i*MAX_OUT_LEN+j) +: 2].
REQ-008 SHALL have ports: uo_output  output  16  signed result word; uo_valid  output  1  uo_output valid; uo_done  output  1  run-complete pulse.

Function
REQ-009 SHALL decode weights as 2'b01=+1, 2'b11=-1, 2'b00=0, 2'b10=0.
REQ-010 SHALL implement states IDLE, MULT, OUT, DONE.
REQ-011 SHALL register ena as ena_q every cycle; start = ena & !ena_q.
REQ-012 IDLE: on start, SHALL latch ui_param, clear all MAX_OUT_LEN accumulators and both counters, and go to MULT.
REQ-013 MULT: each edge SHALL sample ui_input and update acc[j] += w[2k][j]*x(2k) + w[2k+1][j]*x(2k+1) for all j < out_len, where k is the pair counter.
REQ-014 MULT SHALL last ceil(in_len/2) edges; when in_len is odd, the final low byte SHALL be ignored.
REQ-015 After the last MULT edge, SHALL enter OUT with output index 0.
REQ-016 Accumulators SHALL be 16-bit signed; products are sign-extended; overflow cannot occur (|sum| <= 2048).
REQ-017 OUT: each edge SHALL register uo_output <= acc[idx] and uo_valid <= 1, then increment idx; after idx = out_len-1, SHALL go to DONE.
REQ-018 DONE: one edge SHALL set uo_valid <= 0 and uo_done <= 1, and go to IDLE.
REQ-019 In IDLE, uo_done SHALL return to 0 on the next edge, so it is a single-cycle pulse.
REQ-020 Latency from the start edge to the first uo_valid SHALL be ceil(in_len/2)+1 edges; uo_valid SHALL be high for exactly out_len consecutive cycles.
REQ-021 Abort: ena = 0 sampled in MULT or OUT SHALL return the block to IDLE, clear uo_valid and uo_output, assert no uo_done, and discard the partial result.
REQ-022 Holding ena high after DONE SHALL NOT restart the block; a new run needs ena low for at least one cycle.
REQ-023 ui_param and ui_weights changes after the start edge SHALL NOT affect config; weights are read live and must stay stable during MULT.
REQ-024 Indices j >= out_len and pairs beyond in_len SHALL be ignored.

Reset
REQ-025 rst high SHALL asynchronously force: state=IDLE, ena_q=0, accumulators=0, counters=0, latched param=7'h7F, uo_output=0, uo_valid=0, uo_done=0.
REQ-026 Reset asserted mid-run SHALL abandon the run with no uo_valid and no uo_done; the first start after deassertion SHALL behave as a fresh run.

Verification
REQ-027 Reset: rst pulse mid-MULT -> all outputs 0 immediately; block idles until the next ena rising edge.
REQ-028 param in_len=2, out_len=1; w[0][0]=01, w[1][0]=11; ui_input=16'h0503 -> one valid word 16'h0002, uo_done one cycle later.
REQ-029 Full size, all weights 01, ui_input=16'h7F7F for 8 cycles -> 8 valid words each 16'h07F0, then uo_done.
REQ-030 Full size, all weights 11, ui_input=16'h8080 -> 8 words of 16'h0800; with all weights 10 -> 8 words of 16'h0000.
REQ-031 in_len=3, out_len=2, weights 01, inputs 16'h0102 then 16'h04FF -> both words 16'h0007 (byte FF ignored).
REQ-032 ena dropped on the 3rd MULT edge -> no uo_valid/uo_done; a rerun with the REQ-028 stimulus -> 16'h0002.
